// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state
// encoding, opcodes, ALU operation codes, mux select encodings and the
// bundle of control outputs driven by the FSM.
package mc_pkg;

  // FSM states, encoded in sequence order with FETCH at zero.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Opcodes recognised by the control path.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Operation codes handed to the ALU decoder.
  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_SLT   = 4'b0010;
  localparam logic [3:0] ALUOP_AND   = 4'b0100;
  localparam logic [3:0] ALUOP_OR    = 4'b0101;
  localparam logic [3:0] ALUOP_XOR   = 4'b0110;
  localparam logic [3:0] ALUOP_LUI   = 4'b0111;
  localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

  // ALU B input select.
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  // Next-PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Instruction class seen by the FSM after opcode decode.
  typedef enum logic [2:0] {
    IC_RTYPE   = 3'd0,
    IC_LW      = 3'd1,
    IC_SW      = 3'd2,
    IC_BEQ     = 3'd3,
    IC_BNE     = 3'd4,
    IC_IMM     = 3'd5,
    IC_JUMP    = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_t;

  // All control outputs of the FSM as one bundle, so a single '0 clears them.
  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_opdec.sv
// Combinational opcode decoder: classifies the IR opcode and supplies the
// ALU operation and immediate extension mode used by immediate instructions.
module mc_opdec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  output iclass_t    iclass,
  output logic [3:0] imm_aluop,
  output logic       imm_extop
);

  // Map opcode to instruction class; anything unlisted is illegal.
  always_comb begin
    iclass = IC_ILLEGAL;
    case (op)
      OP_RTYPE: iclass = IC_RTYPE;
      OP_LW:    iclass = IC_LW;
      OP_SW:    iclass = IC_SW;
      OP_BEQ:   iclass = IC_BEQ;
      OP_BNE:   iclass = IC_BNE;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:
                iclass = IC_IMM;
      OP_J:     iclass = IC_JUMP;
      default:  iclass = IC_ILLEGAL;
    endcase
  end

  // Immediate-op ALU code; logical ops and lui zero-extend the immediate.
  always_comb begin
    imm_aluop = ALUOP_ADD;
    imm_extop = 1'b0;
    case (op)
      OP_SLTI: imm_aluop = ALUOP_SLT;
      OP_ANDI: begin
        imm_aluop = ALUOP_AND;
        imm_extop = 1'b1;
      end
      OP_ORI: begin
        imm_aluop = ALUOP_OR;
        imm_extop = 1'b1;
      end
      OP_XORI: begin
        imm_aluop = ALUOP_XOR;
        imm_extop = 1'b1;
      end
      OP_LUI: begin
        imm_aluop = ALUOP_LUI;
        imm_extop = 1'b1;
      end
      default: begin
        imm_aluop = ALUOP_ADD;
        imm_extop = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS core. Sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath
// enable, mux select and the aluop for the ALU decoder.
//
// Memory handshake: in FETCH, MEMRD and MEMWR the FSM presents an access
// (address select, and memwrite in MEMWR) and holds it unchanged until the
// cycle in which mem_ready=1; that cycle completes the access and the FSM
// advances on the following edge. mem_ready is ignored in all other states.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [1:0] pcsrc,
  output logic [3:0] aluop,
  output logic       illegal
);

  // Current state is kept under a stable name so checkers can bind to it.
  state_t  state;
  state_t  state_n;
  ctrl_t   ctrl;
  iclass_t iclass;
  logic [3:0] imm_aluop;
  logic       imm_extop;

  mc_opdec u_opdec (
    .op        (op),
    .iclass    (iclass),
    .imm_aluop (imm_aluop),
    .imm_extop (imm_extop)
  );

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and output decode; reset forces every output low at once,
  // so a held write strobe drops in the very cycle reset is raised.
  always_comb begin
    ctrl    = '0;
    state_n = state;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.irwrite = 1'b1;
          ctrl.pcen    = 1'b1;
          state_n      = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here from PC + (imm << 2).
        ctrl.alusrcb = SRCB_BRIMM;
        ctrl.aluop   = ALUOP_ADD;
        case (iclass)
          IC_LW, IC_SW:   state_n = S_MEMADR;
          IC_RTYPE:       state_n = S_RTYPEEX;
          IC_BEQ, IC_BNE: state_n = S_BRANCH;
          IC_IMM:         state_n = S_IMMEX;
          IC_JUMP:        state_n = S_JUMP;
          default: begin
            ctrl.illegal = 1'b1;
            state_n      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
        state_n      = (iclass == IC_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
        if (mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        state_n       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        if (mem_ready) state_n = S_FETCH;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_RTYPE;
        state_n      = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        state_n       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.pcen    = (iclass == IC_BEQ) ? zero : ~zero;
        state_n      = S_FETCH;
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = imm_aluop;
        ctrl.extop   = imm_extop;
        state_n      = S_IMMWB;
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
        state_n       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcsrc = PCSRC_JUMP;
        ctrl.pcen  = 1'b1;
        state_n    = S_FETCH;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
    if (reset) begin
      ctrl = '0;
    end
  end

  assign pcen     = ctrl.pcen;
  assign irwrite  = ctrl.irwrite;
  assign iord     = ctrl.iord;
  assign memwrite = ctrl.memwrite;
  assign regwrite = ctrl.regwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign extop    = ctrl.extop;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl. A reference model expands each instruction into its
// expected per-cycle output vector (plus the inputs to drive that cycle);
// the tests replay those queues against the DUT and compare every cycle.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       extop, illegal;
  logic [3:0] aluop;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues: expected outputs and the inputs for each cycle.
  logic [17:0] exp_q[$];
  logic [5:0]  op_q[$];
  logic        rst_q[$];
  logic        mr_q[$];
  logic        z_q[$];

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .extop(extop), .pcsrc(pcsrc),
    .aluop(aluop), .illegal(illegal)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Driver: apply one cycle of inputs at the falling edge, sample shortly after.
  task automatic drive_cycle(input logic [5:0] o, input logic r, input logic mr,
                             input logic z, output outs_t obs);
    @(negedge clk);
    op = o; reset = r; mem_ready = mr; zero = z;
    #1;
    obs = {pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, extop, pcsrc, aluop, illegal};
  endtask

  task automatic push(input logic [5:0] o, input logic r, input logic mr,
                      input logic z, input outs_t e);
    op_q.push_back(o); rst_q.push_back(r); mr_q.push_back(mr);
    z_q.push_back(z);  exp_q.push_back(e);
  endtask

  // Reference model: expected cycle list for one instruction.
  // fw = FETCH wait cycles, mw = MEMRD/MEMWR wait cycles, bz = branch zero
  // (0/1 forced, 2 random).
  task automatic model_instr(input logic [5:0] o, input int fw, input int mw,
                             input int bz);
    outs_t e;
    logic  z;
    logic  legal;
    legal = o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
                      6'b001110, 6'b001111, 6'b000010};
    for (int i = 0; i < fw; i++) begin
      e = '0; e.alusrcb = 2'b01;
      push(o, 1'b0, 1'b0, rbit(), e);
    end
    e = '0; e.alusrcb = 2'b01; e.pcen = 1'b1; e.irwrite = 1'b1;
    push(o, 1'b0, 1'b1, rbit(), e);
    e = '0; e.alusrcb = 2'b11; e.illegal = !legal;
    push(o, 1'b0, rbit(), rbit(), e);
    case (o)
      6'b100011: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        push(o, 1'b0, rbit(), rbit(), e);
        e = '0; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'b0, rbit(), e);
        push(o, 1'b0, 1'b1, rbit(), e);
        e = '0; e.memtoreg = 1'b1; e.regwrite = 1'b1;
        push(o, 1'b0, rbit(), rbit(), e);
      end
      6'b101011: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        push(o, 1'b0, rbit(), rbit(), e);
        e = '0; e.iord = 1'b1; e.memwrite = 1'b1;
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'b0, rbit(), e);
        push(o, 1'b0, 1'b1, rbit(), e);
      end
      6'b000000: begin
        e = '0; e.alusrca = 1'b1; e.aluop = 4'b1111;
        push(o, 1'b0, rbit(), rbit(), e);
        e = '0; e.regdst = 1'b1; e.regwrite = 1'b1;
        push(o, 1'b0, rbit(), rbit(), e);
      end
      6'b000100, 6'b000101: begin
        z = (bz == 2) ? rbit() : 1'(bz);
        e = '0; e.alusrca = 1'b1; e.aluop = 4'b0001; e.pcsrc = 2'b01;
        e.pcen = (o == 6'b000100) ? z : !z;
        push(o, 1'b0, rbit(), z, e);
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110,
      6'b001111: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        case (o)
          6'b001010: e.aluop = 4'b0010;
          6'b001100: begin e.aluop = 4'b0100; e.extop = 1'b1; end
          6'b001101: begin e.aluop = 4'b0101; e.extop = 1'b1; end
          6'b001110: begin e.aluop = 4'b0110; e.extop = 1'b1; end
          6'b001111: begin e.aluop = 4'b0111; e.extop = 1'b1; end
          default:   e.aluop = 4'b0000;
        endcase
        push(o, 1'b0, rbit(), rbit(), e);
        e = '0; e.regwrite = 1'b1;
        push(o, 1'b0, rbit(), rbit(), e);
      end
      6'b000010: begin
        e = '0; e.pcsrc = 2'b10; e.pcen = 1'b1;
        push(o, 1'b0, rbit(), rbit(), e);
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    outs_t e, obs, ex;
    int cyc = 0;
    // Reset from power-up, then an sw stalled in MEMWR hit by a 3-cycle reset.
    push(6'b101011, 1'b1, 1'b1, 1'b1, '0);
    push(6'b101011, 1'b1, 1'b1, 1'b0, '0);
    e = '0; e.alusrcb = 2'b01; e.pcen = 1'b1; e.irwrite = 1'b1;
    push(6'b101011, 1'b0, 1'b1, 1'b0, e);
    e = '0; e.alusrcb = 2'b11;
    push(6'b101011, 1'b0, 1'b0, 1'b0, e);
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
    push(6'b101011, 1'b0, 1'b0, 1'b0, e);
    e = '0; e.iord = 1'b1; e.memwrite = 1'b1;
    push(6'b101011, 1'b0, 1'b0, 1'b0, e);
    push(6'b101011, 1'b0, 1'b0, 1'b1, e);
    for (int i = 0; i < 3; i++) push(6'b101011, 1'b1, 1'b0, 1'b1, '0);
    e = '0; e.alusrcb = 2'b01;
    push(6'b101011, 1'b0, 1'b0, 1'b0, e);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      drive_cycle(op_q.pop_front(), rst_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), obs);
      n_checks++; cyc++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h expected %h", cyc, obs, ex);
      end
    end
  endtask

  task automatic test_rtype();
    outs_t obs, ex;
    int cyc = 0;
    model_instr(6'b000000, 0, 0, 2);
    model_instr(6'b000000, 2, 0, 2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      drive_cycle(op_q.pop_front(), rst_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), obs);
      n_checks++; cyc++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL rtype cycle %0d: got %h expected %h", cyc, obs, ex);
      end
    end
  endtask

  task automatic test_mem_wait();
    outs_t obs, ex;
    int cyc = 0;
    model_instr(6'b100011, 0, 2, 2);
    model_instr(6'b100011, 0, 0, 2);
    model_instr(6'b101011, 1, 3, 2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      drive_cycle(op_q.pop_front(), rst_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), obs);
      n_checks++; cyc++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL mem_wait cycle %0d: got %h expected %h", cyc, obs, ex);
      end
    end
  endtask

  task automatic test_branch();
    outs_t obs, ex;
    int cyc = 0;
    model_instr(6'b000100, 0, 0, 1);
    model_instr(6'b000101, 0, 0, 1);
    model_instr(6'b000100, 0, 0, 0);
    model_instr(6'b000101, 0, 0, 0);
    model_instr(6'b000010, 0, 0, 2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      drive_cycle(op_q.pop_front(), rst_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), obs);
      n_checks++; cyc++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL branch cycle %0d: got %h expected %h", cyc, obs, ex);
      end
    end
  endtask

  task automatic test_imm();
    outs_t obs, ex;
    int cyc = 0;
    model_instr(6'b001101, 0, 0, 2);
    model_instr(6'b001010, 0, 0, 2);
    model_instr(6'b001000, 0, 0, 2);
    model_instr(6'b001001, 0, 0, 2);
    model_instr(6'b001100, 0, 0, 2);
    model_instr(6'b001110, 0, 0, 2);
    model_instr(6'b001111, 0, 0, 2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      drive_cycle(op_q.pop_front(), rst_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), obs);
      n_checks++; cyc++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL imm cycle %0d: got %h expected %h", cyc, obs, ex);
      end
    end
  endtask

  task automatic test_illegal();
    outs_t obs, ex;
    int cyc = 0;
    model_instr(6'b111111, 0, 0, 2);
    model_instr(6'b000001, 1, 0, 2);
    model_instr(6'b000000, 0, 0, 2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      drive_cycle(op_q.pop_front(), rst_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), obs);
      n_checks++; cyc++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL illegal cycle %0d: got %h expected %h", cyc, obs, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal_ops[13];
    logic [5:0] o;
    outs_t obs, ex;
    int cyc = 0;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                  6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
                  6'b001110, 6'b001111, 6'b000010};
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) o = 6'($urandom_range(0, 63));
      else o = legal_ops[$urandom_range(0, 12)];
      model_instr(o, $urandom_range(0, 2), $urandom_range(0, 2), 2);
    end
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      drive_cycle(op_q.pop_front(), rst_q.pop_front(), mr_q.pop_front(), z_q.pop_front(), obs);
      n_checks++; cyc++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d op=%b: got %h expected %h", cyc, op, obs, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem_wait();
    test_branch();
    test_imm();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
